// File: rtl/hazard_scoreboard.sv
// Register scoreboard for a 5-stage pipeline: tracks pending writebacks, raises freeze and picks forwarding paths.
// Define HAZARD_SCOREBOARD_FORWARDING_EN to enable EXE/MEM forwarding; otherwise every RAW hazard stalls.
module hazard_scoreboard #(
    parameter int REG_W  = 4,
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam int NREG = 2 ** REG_W;
    localparam int PW   = $clog2(WB_LAT + 1);
    localparam logic [PW-1:0]    LAT     = PW'(WB_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]   pend [NREG];
    logic [NREG-1:0] ld;

    logic          active;
    logic          issue;
    logic [PW-1:0] pend_a;
    logic [PW-1:0] pend_b;
    logic          stall_a;
    logic          stall_b;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;

    assign active = id_valid & ~flush & ~rst;
    assign issue  = id_valid & id_wb_en & ~freeze & ~flush;
    assign pend_a = pend[id_rn];
    assign pend_b = pend[id_src2];

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    localparam logic [PW-1:0] LAT_M1 = PW'(WB_LAT - 1);

    // pend==WB_LAT means the producer sits in EXE, WB_LAT-1 means MEM; older still must wait for WB.
    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        sel_a   = 2'b00;
        sel_b   = 2'b00;
        if (pend_a == LAT) begin
            if (ld[id_rn]) stall_a = 1'b1;
            else           sel_a   = 2'b01;
        end else if (pend_a == LAT_M1 && pend_a != '0) begin
            sel_a = 2'b10;
        end else if (pend_a != '0) begin
            stall_a = 1'b1;
        end
        if (pend_b == LAT) begin
            if (ld[id_src2]) stall_b = 1'b1;
            else             sel_b   = 2'b01;
        end else if (pend_b == LAT_M1 && pend_b != '0) begin
            sel_b = 2'b10;
        end else if (pend_b != '0) begin
            stall_b = 1'b1;
        end
    end
`else
    logic unused_ld;
    assign unused_ld = ^ld;

    always_comb begin
        stall_a = (pend_a != '0);
        stall_b = (pend_b != '0);
        sel_a   = 2'b00;
        sel_b   = 2'b00;
    end
`endif

    assign freeze    = active & (stall_a | (id_two_src & stall_b));
    assign fwd_sel_a = active ? sel_a : 2'b00;
    assign fwd_sel_b = (active & id_two_src) ? sel_b : 2'b00;

    // A fresh issue to a register overrides its countdown in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
            ld          <= '0;
            stall_count <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && id_dest == REG_W'(r)) begin
                    pend[r] <= LAT;
                    ld[r]   <= id_mem_read;
                end else if (pend[r] != '0) begin
                    pend[r] <= pend[r] - PW'(1);
                end
            end
            if (freeze && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 4: register address width; 2**REG_W registers are tracked.
REQ-002 SHALL have parameter WB_LAT, default 2: cycles from issue out of ID until the result is readable in ID, via EXE and MEM, with the WB write on negedge.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn  in  REG_W  source 1.
- id_src2  in  REG_W  source 2; used only when id_two_src=1.
- id_two_src  in  1  source 2 is a register read.
- id_wb_en  in  1  ID instruction writes id_dest.
- id_dest  in  REG_W  destination register.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch taken in EXE; the ID instruction is squashed.
- freeze  out  1  hold PC, IF/ID and ID/EXE; insert a bubble into EXE.
- fwd_sel_a  out  2  source 1 select: 00=regfile, 01=EXE result, 10=MEM result.
- fwd_sel_b  out  2  source 2 select, same encoding.
- stall_count  out  CNT_W  number of cycles in which freeze was asserted.

Function
REQ-005 SHALL keep, per register r, a down-counter pend[r] of width clog2(WB_LAT+1) and a flag ld[r].
REQ-006 SHALL treat "issue" as id_valid & id_wb_en & !freeze & !flush; on issue, the next edge sets pend[id_dest]=WB_LAT and ld[id_dest]=id_mem_read.
REQ-007 SHALL decrement every nonzero pend[r] on each edge; for the issued id_dest in the same edge, the issue load wins over the decrement.
REQ-008 SHALL hold ld[r] until pend[r] reaches 0, then ignore it.
REQ-009 SHALL consider source 1 used whenever id_valid=1, and source 2 used only when id_valid & id_two_src; all register indices are tracked, including 0.
REQ-010 SHALL compute freeze, fwd_sel_a and fwd_sel_b combinationally from the registered scoreboard and the ID inputs, with zero-cycle latency.
REQ-011 SHALL force freeze=0 and both fwd_sel outputs to 00 when flush=1 or id_valid=0.
REQ-012 SHALL increment stall_count by 1 on each edge where freeze=1, saturating at 2**CNT_W-1 with no wrap.
REQ-013 SHALL not track a flushed or frozen ID instruction; it is re-presented or discarded by the pipeline.
REQ-014 SHALL, when both sources name the same pending register, produce identical decisions for both.

Reset
REQ-015 SHALL, when rst=1 at an edge, clear all pend[r], all ld[r] and stall_count, regardless of any in-flight state or concurrent issue.
REQ-016 SHALL drive freeze=0 and fwd_sel_a=fwd_sel_b=00 while rst=1.

Configuration
REQ-017 SHALL support the macro HAZARD_SCOREBOARD_FORWARDING_EN, which compiles forwarding in or out.
REQ-018 With HAZARD_SCOREBOARD_FORWARDING_EN defined, for a used source with pend[r]!=0:
- pend=WB_LAT and ld=0: fwd_sel=01, no freeze.
- pend=WB_LAT and ld=1: freeze, a load-use stall.
- pend=WB_LAT-1: fwd_sel=10, no freeze.
- pend<WB_LAT-1: freeze.
REQ-019 Without HAZARD_SCOREBOARD_FORWARDING_EN, SHALL assert freeze for any used source with pend[r]!=0, and tie fwd_sel_a and fwd_sel_b to 00.

Verification (WB_LAT=2)
REQ-020 SHALL pass, without forwarding: issue writer R3, then reader id_rn=3 -> freeze=1 for 2 cycles, then 0 with fwd 00; stall_count=2.
REQ-021 SHALL pass, with forwarding: issue ALU writer R3, then reader id_rn=3 -> freeze=0, fwd_sel_a=01; the next reader, with id_two_src=1 and id_src2=3 -> fwd_sel_b=10.
REQ-022 SHALL pass, with forwarding: issue load R5, then reader id_rn=5 -> freeze=1 for 1 cycle, then fwd_sel_a=10; stall_count=1.
REQ-023 SHALL pass: writer R7 presented with flush=1, then reader id_rn=7 -> freeze=0 and fwd 00 (not tracked).
REQ-024 SHALL pass: R9 pending, reader with id_two_src=0 and id_src2=9 -> freeze=0; then rst=1 for 1 cycle with R3 pending, followed by reader R3 -> freeze=0 and stall_count=0.
